// File: rtl/capture_ctrl.sv
// Capture sequencer for the sample RAM: writes decimated samples into a circular
// buffer, arms the trigger once pre-trigger history is full, and stops trig_pos samples later.
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          wrt_smpl,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  input  logic          clr_cap_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          set_capture_done,
  output logic          capture_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW-1:0] LAST  = AW'(ENTRIES - 1);
  localparam logic [AW-1:0] FULL  = AW'(ENTRIES);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(ENTRIES);

  state_t        state, state_nxt;
  logic [AW-1:0] smpl_cnt, trig_cnt;
  logic [AW-1:0] tp, smpl_inc, smpl_nxt;
  logic [AW:0]   arm_thr;
  logic          done_cond;

  // A post-trigger count of ENTRIES or more would overwrite the trigger point itself.
  assign tp       = (trig_pos > LAST) ? LAST : trig_pos;
  assign arm_thr  = DEPTH - {1'b0, tp};
  assign smpl_inc = (smpl_cnt == FULL) ? smpl_cnt : smpl_cnt + 1'b1;
  assign smpl_nxt = we ? smpl_inc : smpl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    done_cond = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: if (run && !capture_done) state_nxt = RUN;
      RUN: begin
        done_cond = triggered && (trig_cnt == tp);
        we        = wrt_smpl && !done_cond && run;
        if (!run)           state_nxt = IDLE;
        else if (done_cond) state_nxt = DONE;
      end
      DONE: if (clr_cap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr            <= '0;
      smpl_cnt         <= '0;
      trig_cnt         <= '0;
      armed            <= 1'b0;
      set_capture_done <= 1'b0;
      capture_done     <= 1'b0;
    end else begin
      set_capture_done <= 1'b0;
      case (state)
        IDLE: begin
          armed <= 1'b0;
          if (state_nxt == RUN) begin
            waddr    <= '0;
            smpl_cnt <= '0;
            trig_cnt <= '0;
          end
        end
        RUN: begin
          if (!run) begin
            armed <= 1'b0;
          end else if (done_cond) begin
            armed            <= 1'b0;
            set_capture_done <= 1'b1;
            capture_done     <= 1'b1;
          end else begin
            if (we) begin
              waddr    <= (waddr == LAST) ? '0 : waddr + 1'b1;
              smpl_cnt <= smpl_inc;
              if (triggered) trig_cnt <= trig_cnt + 1'b1;
            end
            // Armed as soon as the write that completes the history lands.
            if ({1'b0, smpl_nxt} >= arm_thr) armed <= 1'b1;
          end
        end
        DONE: if (clr_cap_done) capture_done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ENTRIES=16: vector table for the short
// sequences, hand-written loops for the long wrap/arm/trigger scenarios.
module tb_capture_ctrl;

  localparam int ENTRIES = 16;
  localparam int AW      = 5;

  logic          clk, rst_n;
  logic          run, wrt_smpl, triggered, clr_cap_done;
  logic [AW-1:0] trig_pos;
  logic          we, armed, set_capture_done, capture_done;
  logic [AW-1:0] waddr;

  int n_chk  = 0;
  int n_fail = 0;

  capture_ctrl #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .wrt_smpl         (wrt_smpl),
    .triggered        (triggered),
    .trig_pos         (trig_pos),
    .clr_cap_done     (clr_cap_done),
    .we               (we),
    .waddr            (waddr),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          run, ws, trig;
    logic [AW-1:0] tp;
    logic          clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic          armed, scd, cd;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, mid-cycle.
  task automatic drive(input logic r, input logic ws, input logic tg,
                       input logic [AW-1:0] p, input logic clr);
    @(negedge clk);
    run = r; wrt_smpl = ws; triggered = tg; trig_pos = p; clr_cap_done = clr;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_we, input int e_waddr,
                            input logic e_armed, input logic e_scd, input logic e_cd);
    check({tag, ".we"},    int'(we),               int'(e_we));
    check({tag, ".waddr"}, int'(waddr),            e_waddr);
    check({tag, ".armed"}, int'(armed),            int'(e_armed));
    check({tag, ".scd"},   int'(set_capture_done), int'(e_scd));
    check({tag, ".cd"},    int'(capture_done),     int'(e_cd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // trig_pos=0 capture, DONE hold, clr+run together, abort, ignored clr.
    //          run ws trg tp  clr   we waddr arm scd cd
    tbl[0]  = '{0, 0, 0, 5'd0, 0,   0, 5'd0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 5'd0, 0,   0, 5'd0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 5'd0, 0,   1, 5'd0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 5'd0, 0,   1, 5'd1, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 5'd0, 0,   0, 5'd2, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 5'd0, 0,   0, 5'd2, 0, 1, 1};
    tbl[6]  = '{1, 1, 1, 5'd0, 0,   0, 5'd2, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 5'd0, 1,   0, 5'd2, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 5'd0, 0,   0, 5'd2, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 5'd0, 0,   1, 5'd0, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 5'd0, 1,   0, 5'd1, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 5'd0, 0,   0, 5'd1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 5'd0, 1,   0, 5'd1, 0, 0, 0};

    rst_n = 1'b0;
    run = 0; wrt_smpl = 0; triggered = 0; trig_pos = '0; clr_cap_done = 0;
    #2;
    check_outs("reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].run, tbl[i].ws, tbl[i].trig, tbl[i].tp, tbl[i].clr);
      check_outs($sformatf("vec%0d", i), tbl[i].we, int'(tbl[i].waddr),
                 tbl[i].armed, tbl[i].scd, tbl[i].cd);
    end

    // trig_pos=4: armed after the 12th write, wrap 15->0, then 4 post-trigger writes.
    drive(1, 1, 0, 5'd4, 0);
    check("b_idle.we", int'(we), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 5'd4, 0);
      check($sformatf("b_w%0d.we", i),    int'(we),    1);
      check($sformatf("b_w%0d.waddr", i), int'(waddr), i % ENTRIES);
      check($sformatf("b_w%0d.armed", i), int'(armed), (i >= 12) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 5'd4, 0);
      check_outs($sformatf("b_post%0d", k), 1, 4 + k, 1, 0, 0);
    end
    drive(1, 1, 1, 5'd4, 0);
    check_outs("b_stop", 0, 8, 1, 0, 0);
    drive(1, 1, 1, 5'd4, 0);
    check_outs("b_done1", 0, 8, 0, 1, 1);
    drive(1, 1, 1, 5'd4, 0);
    check_outs("b_done2", 0, 8, 0, 0, 1);
    drive(0, 0, 0, 5'd4, 1);
    check("b_clr.cd", int'(capture_done), 1);
    drive(0, 0, 0, 5'd4, 0);
    check("b_idle2.cd", int'(capture_done), 0);

    // trig_pos=20 clamps to 15: armed after the first write, 15 post-trigger writes.
    drive(1, 1, 0, 5'd20, 0);
    check("c_idle.we", int'(we), 0);
    drive(1, 1, 0, 5'd20, 0);
    check_outs("c_w0", 1, 0, 0, 0, 0);
    drive(1, 1, 0, 5'd20, 0);
    check_outs("c_w1", 1, 1, 1, 0, 0);
    for (int k = 0; k < 15; k++) begin
      drive(1, 1, 1, 5'd20, 0);
      check_outs($sformatf("c_post%0d", k), 1, (2 + k) % ENTRIES, 1, 0, 0);
    end
    drive(1, 1, 1, 5'd20, 0);
    check_outs("c_stop", 0, 1, 1, 0, 0);
    drive(1, 1, 1, 5'd20, 0);
    check_outs("c_done", 0, 1, 0, 1, 1);
    drive(0, 0, 0, 5'd20, 1);
    drive(0, 0, 0, 5'd20, 0);
    check("c_idle2.cd", int'(capture_done), 0);

    // Asynchronous reset mid-capture, then restart on the first edge after release.
    drive(1, 1, 0, 5'd4, 0);
    drive(1, 1, 0, 5'd4, 0);
    check_outs("d_w0", 1, 0, 0, 0, 0);
    drive(1, 1, 1, 5'd4, 0);
    check_outs("d_w1", 1, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check_outs("d_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; triggered = 0;
    #1;
    check("d_rel.we", int'(we), 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 5'd4, 0);
      check_outs($sformatf("d_run%0d", k), 1, k, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
